// File: rtl/run_seq_pkg.sv
// Shared types for the run sequencer: controller states and the dump counter
// width helper.
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        DUMP_C = 3'd2,
        DUMP_M = 3'd3,
        DONE   = 3'd4
    } run_state_t;

    // Counter wide enough to hold the dump length itself.
    function automatic int dump_cnt_w(input int dump_cyc);
        return $clog2(dump_cyc + 1);
    endfunction

endpackage

// File: rtl/dump_pulser.sv
// Loadable down-counter producing a DUMP_CYC-long registered strobe and a
// flag marking the strobe's final cycle.
module dump_pulser
    import run_seq_pkg::*;
#(
    parameter int DUMP_CYC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic strobe,
    output logic fin
);

    localparam int CW = dump_cnt_w(DUMP_CYC);
    localparam logic [CW-1:0] LOAD_VAL = CW'(DUMP_CYC);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt;

    // fin is high during the last strobe cycle so the next stage can load on
    // the same edge that drops this strobe, leaving no gap between dumps.
    assign fin = (cnt == ONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            strobe <= 1'b0;
        end else if (load) begin
            cnt    <= LOAD_VAL;
            strobe <= 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
            if (fin) begin
                strobe <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Run controller: starts N_CH CPU channels, gathers completions, counts cycles
// with optional timeout, then issues cache and memory dump strobes.
//
// state  | meaning
// IDLE   | waiting for start; last run's results held
// RUN    | start_work high, counting cycles, collecting end_work
// DUMP_C | cache dump strobe active
// DUMP_M | memory dump strobe active
// DONE   | end_work_test high until start drops
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int N_CH      = 1,
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 0,
    parameter int DUMP_CYC  = 1,
    parameter int M_DUMP_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_CH-1:0]  end_work,
    output logic [N_CH-1:0]  start_work,
    output logic             c_dump,
    output logic             m_dump,
    output logic [CNT_W-1:0] cycles,
    output logic [N_CH-1:0]  done_mask,
    output logic             timed_out,
    output logic             end_work_test
);

    localparam logic [N_CH-1:0]  ALL_CH  = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    run_state_t       state;
    logic [CNT_W-1:0] cyc_next;
    logic [N_CH-1:0]  mask_next;
    logic             all_done;
    logic             to_hit;
    logic             run_exit;
    logic             m_load;
    logic             c_fin;
    logic             m_fin;

    always_comb begin
        cyc_next  = (cycles == CNT_MAX) ? cycles : cycles + CNT_ONE;
        mask_next = done_mask | end_work;
        all_done  = (mask_next == ALL_CH);
        to_hit    = (TIMEOUT != 0) && (cyc_next == TO_VAL);
        run_exit  = (state == RUN) && (all_done || to_hit);
        m_load    = (M_DUMP_EN != 0) && (state == DUMP_C) && c_fin;
    end

    dump_pulser #(.DUMP_CYC(DUMP_CYC)) u_c_dump (
        .clk    (clk),
        .reset  (reset),
        .load   (run_exit),
        .strobe (c_dump),
        .fin    (c_fin)
    );

    dump_pulser #(.DUMP_CYC(DUMP_CYC)) u_m_dump (
        .clk    (clk),
        .reset  (reset),
        .load   (m_load),
        .strobe (m_dump),
        .fin    (m_fin)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            start_work    <= '0;
            cycles        <= '0;
            done_mask     <= '0;
            timed_out     <= 1'b0;
            end_work_test <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        start_work <= ALL_CH;
                        cycles     <= '0;
                        done_mask  <= '0;
                        timed_out  <= 1'b0;
                    end
                end
                RUN: begin
                    cycles    <= cyc_next;
                    done_mask <= mask_next;
                    // all-done takes priority over a coincident timeout
                    if (run_exit) begin
                        state      <= DUMP_C;
                        start_work <= '0;
                        timed_out  <= !all_done;
                    end
                end
                DUMP_C: begin
                    if (c_fin) begin
                        if (M_DUMP_EN != 0) begin
                            state <= DUMP_M;
                        end else begin
                            state         <= DONE;
                            end_work_test <= 1'b1;
                        end
                    end
                end
                DUMP_M: begin
                    if (m_fin) begin
                        state         <= DONE;
                        end_work_test <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state         <= IDLE;
                        end_work_test <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: several parameterisations driven
// scenario by scenario with hand-computed expectations.
module tb_run_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // a: basic instance (N_CH=1, no timeout, DUMP_CYC=1, memory dump on)
    logic        a_start = 0, a_end = 0;
    logic        a_sw, a_cd, a_md, a_to, a_ewt, a_dm;
    logic [31:0] a_cyc;
    // b: four channels
    logic [3:0]  b_end = 0, b_sw, b_dm;
    logic        b_start = 0, b_cd, b_md, b_to, b_ewt;
    logic [31:0] b_cyc;
    // c: two channels, timeout 20
    logic [1:0]  c_end = 0, c_sw, c_dm;
    logic        c_start = 0, c_cd, c_md, c_to, c_ewt;
    logic [31:0] c_cyc;
    // d: DUMP_CYC=3, no memory dump
    logic        d_start = 0, d_end = 0, d_sw, d_cd, d_md, d_to, d_ewt, d_dm;
    logic [31:0] d_cyc;
    // e: 3-bit cycle counter
    logic        e_start = 0, e_end = 0, e_sw, e_cd, e_md, e_to, e_ewt, e_dm;
    logic [2:0]  e_cyc;

    run_sequencer #(.N_CH(1)) u_a (
        .clk(clk), .reset(rst), .start(a_start), .end_work(a_end),
        .start_work(a_sw), .c_dump(a_cd), .m_dump(a_md), .cycles(a_cyc),
        .done_mask(a_dm), .timed_out(a_to), .end_work_test(a_ewt));

    run_sequencer #(.N_CH(4)) u_b (
        .clk(clk), .reset(rst), .start(b_start), .end_work(b_end),
        .start_work(b_sw), .c_dump(b_cd), .m_dump(b_md), .cycles(b_cyc),
        .done_mask(b_dm), .timed_out(b_to), .end_work_test(b_ewt));

    run_sequencer #(.N_CH(2), .TIMEOUT(20)) u_c (
        .clk(clk), .reset(rst), .start(c_start), .end_work(c_end),
        .start_work(c_sw), .c_dump(c_cd), .m_dump(c_md), .cycles(c_cyc),
        .done_mask(c_dm), .timed_out(c_to), .end_work_test(c_ewt));

    run_sequencer #(.N_CH(1), .DUMP_CYC(3), .M_DUMP_EN(0)) u_d (
        .clk(clk), .reset(rst), .start(d_start), .end_work(d_end),
        .start_work(d_sw), .c_dump(d_cd), .m_dump(d_md), .cycles(d_cyc),
        .done_mask(d_dm), .timed_out(d_to), .end_work_test(d_ewt));

    run_sequencer #(.N_CH(1), .CNT_W(3)) u_e (
        .clk(clk), .reset(rst), .start(e_start), .end_work(e_end),
        .start_work(e_sw), .c_dump(e_cd), .m_dump(e_md), .cycles(e_cyc),
        .done_mask(e_dm), .timed_out(e_to), .end_work_test(e_ewt));

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({a_sw, a_cd, a_md, a_to, a_ewt, a_dm} !== 6'b0 || a_cyc !== 32'd0) begin
            bad++;
            $display("FAIL reset_a: got sw=%b cd=%b md=%b to=%b ewt=%b dm=%b cyc=%0d, want all 0",
                     a_sw, a_cd, a_md, a_to, a_ewt, a_dm, a_cyc);
        end
        total++;
        if ({b_sw, b_dm, b_cd, b_md, b_to, b_ewt} !== 12'b0 || b_cyc !== 32'd0) begin
            bad++;
            $display("FAIL reset_b: got sw=%b dm=%b cd=%b md=%b to=%b ewt=%b cyc=%0d, want all 0",
                     b_sw, b_dm, b_cd, b_md, b_to, b_ewt, b_cyc);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic;
        a_start = 1;
        @(negedge clk);                     // after E0
        total++;
        if (a_sw !== 1'b1 || a_cyc !== 32'd0) begin
            bad++; $display("FAIL basic_start: sw=%b cyc=%0d, want sw=1 cyc=0", a_sw, a_cyc);
        end
        repeat (4) @(negedge clk);          // after E0+4
        total++;
        if (a_sw !== 1'b1 || a_cyc !== 32'd4 || a_cd !== 1'b0) begin
            bad++; $display("FAIL basic_run4: sw=%b cyc=%0d cd=%b, want 1 4 0", a_sw, a_cyc, a_cd);
        end
        a_end = 1;
        @(negedge clk);                     // after E0+5
        a_end = 0;
        total++;
        if (a_cyc !== 32'd5 || a_to !== 1'b0 || a_sw !== 1'b0 || a_cd !== 1'b1 || a_md !== 1'b0 || a_ewt !== 1'b0 || a_dm !== 1'b1) begin
            bad++; $display("FAIL basic_exit: cyc=%0d to=%b sw=%b cd=%b md=%b ewt=%b dm=%b, want 5 0 0 1 0 0 1",
                            a_cyc, a_to, a_sw, a_cd, a_md, a_ewt, a_dm);
        end
        @(negedge clk);
        total++;
        if (a_cd !== 1'b0 || a_md !== 1'b1 || a_ewt !== 1'b0) begin
            bad++; $display("FAIL basic_mdump: cd=%b md=%b ewt=%b, want 0 1 0", a_cd, a_md, a_ewt);
        end
        @(negedge clk);
        total++;
        if (a_cd !== 1'b0 || a_md !== 1'b0 || a_ewt !== 1'b1 || a_cyc !== 32'd5) begin
            bad++; $display("FAIL basic_done: cd=%b md=%b ewt=%b cyc=%0d, want 0 0 1 5", a_cd, a_md, a_ewt, a_cyc);
        end
    endtask

    task automatic test_rearm;
        a_start = 0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (a_ewt !== 1'b0 || a_cyc !== 32'd5 || a_dm !== 1'b1 || a_sw !== 1'b0) begin
            bad++; $display("FAIL rearm_hold: ewt=%b cyc=%0d dm=%b sw=%b, want 0 5 1 0", a_ewt, a_cyc, a_dm, a_sw);
        end
        a_start = 1;
        @(negedge clk);                     // after second E0
        total++;
        if (a_sw !== 1'b1 || a_cyc !== 32'd0 || a_dm !== 1'b0) begin
            bad++; $display("FAIL rearm_start: sw=%b cyc=%0d dm=%b, want 1 0 0", a_sw, a_cyc, a_dm);
        end
        @(negedge clk);
        a_end = 1;
        @(negedge clk);                     // after E0+2
        a_end = 0;
        total++;
        if (a_cyc !== 32'd2 || a_cd !== 1'b1) begin
            bad++; $display("FAIL rearm_exit: cyc=%0d cd=%b, want 2 1", a_cyc, a_cd);
        end
        for (int i = 0; i < 10 && a_ewt !== 1'b1; i++) @(negedge clk);
        total++;
        if (a_ewt !== 1'b1) begin
            bad++; $display("FAIL rearm_done: ewt=%b, want 1 within 10 cycles", a_ewt);
        end
    endtask

    task automatic test_reset_midrun;
        a_start = 0;
        @(negedge clk);
        a_start = 1;
        @(negedge clk);                     // after E0
        repeat (3) @(negedge clk);          // after E0+3
        #2 rst = 0;
        #1;
        total++;
        if ({a_sw, a_cd, a_md, a_to, a_ewt, a_dm} !== 6'b0 || a_cyc !== 32'd0) begin
            bad++; $display("FAIL midrun_reset: sw=%b cd=%b md=%b to=%b ewt=%b dm=%b cyc=%0d, want all 0",
                            a_sw, a_cd, a_md, a_to, a_ewt, a_dm, a_cyc);
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);                     // fresh E0
        total++;
        if (a_sw !== 1'b1 || a_cyc !== 32'd0) begin
            bad++; $display("FAIL midrun_restart: sw=%b cyc=%0d, want 1 0", a_sw, a_cyc);
        end
        repeat (3) @(negedge clk);
        total++;
        if (a_cyc !== 32'd3) begin
            bad++; $display("FAIL midrun_count: cyc=%0d, want 3", a_cyc);
        end
        a_end = 1;
        @(negedge clk);
        a_end = 0;
        for (int i = 0; i < 10 && a_ewt !== 1'b1; i++) @(negedge clk);
        total++;
        if (a_ewt !== 1'b1 || a_cyc !== 32'd4) begin
            bad++; $display("FAIL midrun_done: ewt=%b cyc=%0d, want 1 4", a_ewt, a_cyc);
        end
    endtask

    task automatic test_accum;
        logic [3:0] exp_dm, exp_sw;
        b_start = 1;
        @(negedge clk);                     // after E0
        for (int k = 1; k <= 10; k++) begin
            case (k)
                2:       b_end = 4'b0100;
                3:       b_end = 4'b0001;
                7:       b_end = 4'b1000;
                10:      b_end = 4'b0010;
                default: b_end = 4'b0000;
            endcase
            @(negedge clk);                 // after E0+k
            b_end = 4'b0000;
            if (k < 2)       exp_dm = 4'b0000;
            else if (k < 3)  exp_dm = 4'b0100;
            else if (k < 7)  exp_dm = 4'b0101;
            else if (k < 10) exp_dm = 4'b1101;
            else             exp_dm = 4'b1111;
            exp_sw = (k < 10) ? 4'b1111 : 4'b0000;
            total++;
            if (b_dm !== exp_dm || b_sw !== exp_sw || b_cyc !== 32'(k)) begin
                bad++; $display("FAIL accum_k%0d: dm=%b sw=%b cyc=%0d, want %b %b %0d",
                                k, b_dm, b_sw, b_cyc, exp_dm, exp_sw, k);
            end
        end
        total++;
        if (b_cd !== 1'b1 || b_to !== 1'b0) begin
            bad++; $display("FAIL accum_exit: cd=%b to=%b, want 1 0", b_cd, b_to);
        end
        for (int i = 0; i < 10 && b_ewt !== 1'b1; i++) @(negedge clk);
        total++;
        if (b_ewt !== 1'b1) begin
            bad++; $display("FAIL accum_done: ewt=%b, want 1", b_ewt);
        end
    endtask

    task automatic test_timeout(input bit late_ch1);
        c_start = 1;
        @(negedge clk);                     // after E0
        total++;
        if (c_to !== 1'b0 || c_sw !== 2'b11) begin
            bad++; $display("FAIL timeout_start%0d: to=%b sw=%b, want 0 11", late_ch1, c_to, c_sw);
        end
        for (int k = 1; k <= 20; k++) begin
            if (k == 3)                  c_end = 2'b01;
            else if (late_ch1 && k == 20) c_end = 2'b10;
            else                         c_end = 2'b00;
            @(negedge clk);
            c_end = 2'b00;
            if (k == 19) begin
                total++;
                if (c_sw !== 2'b11 || c_cd !== 1'b0) begin
                    bad++; $display("FAIL timeout_k19_%0d: sw=%b cd=%b, want 11 0", late_ch1, c_sw, c_cd);
                end
            end
        end
        total++;
        if (c_to !== !late_ch1 || c_cyc !== 32'd20 || c_dm !== (late_ch1 ? 2'b11 : 2'b01) || c_sw !== 2'b00 || c_cd !== 1'b1) begin
            bad++; $display("FAIL timeout_exit%0d: to=%b cyc=%0d dm=%b sw=%b cd=%b, want %b 20 %b 00 1",
                            late_ch1, c_to, c_cyc, c_dm, c_sw, c_cd, !late_ch1, late_ch1 ? 2'b11 : 2'b01);
        end
        @(negedge clk);
        total++;
        if (c_md !== 1'b1 || c_cd !== 1'b0) begin
            bad++; $display("FAIL timeout_mdump%0d: md=%b cd=%b, want 1 0", late_ch1, c_md, c_cd);
        end
        @(negedge clk);
        c_end = 2'b10;                      // ignored outside RUN
        @(negedge clk);
        c_end = 2'b00;
        total++;
        if (c_ewt !== 1'b1 || c_dm !== (late_ch1 ? 2'b11 : 2'b01) || c_to !== !late_ch1) begin
            bad++; $display("FAIL timeout_done%0d: ewt=%b dm=%b to=%b, want 1 %b %b",
                            late_ch1, c_ewt, c_dm, c_to, late_ch1 ? 2'b11 : 2'b01, !late_ch1);
        end
        c_start = 0;
        @(negedge clk);
        total++;
        if (c_ewt !== 1'b0 || c_to !== !late_ch1) begin
            bad++; $display("FAIL timeout_idle%0d: ewt=%b to=%b, want 0 %b", late_ch1, c_ewt, c_to, !late_ch1);
        end
    endtask

    task automatic test_dump3;
        d_start = 1;
        @(negedge clk);
        d_end = 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            d_end = 0;
            total++;
            if (d_cd !== (k <= 3) || d_md !== 1'b0 || d_ewt !== (k >= 4)) begin
                bad++; $display("FAIL dump3_k%0d: cd=%b md=%b ewt=%b, want %b 0 %b",
                                k, d_cd, d_md, d_ewt, (k <= 3), (k >= 4));
            end
        end
    endtask

    task automatic test_saturate;
        e_start = 1;
        @(negedge clk);
        for (int k = 1; k <= 10; k++) begin
            e_end = (k == 10);
            @(negedge clk);
            e_end = 0;
            if (k == 7 || k == 8) begin
                total++;
                if (e_cyc !== 3'd7 || e_sw !== 1'b1) begin
                    bad++; $display("FAIL sat_k%0d: cyc=%0d sw=%b, want 7 1", k, e_cyc, e_sw);
                end
            end
        end
        total++;
        if (e_cyc !== 3'd7 || e_cd !== 1'b1 || e_to !== 1'b0) begin
            bad++; $display("FAIL sat_exit: cyc=%0d cd=%b to=%b, want 7 1 0", e_cyc, e_cd, e_to);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rearm();
        test_reset_midrun();
        test_accum();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_dump3();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
